lsu_v2: RTL
===========

# lsu_v2

Second-generation load/store unit for the RV32I core's memory stage. It runs a valid/ready request interface with a registered response and realigns byte lanes using the address LSBs. Misaligned data-memory accesses are split into two word accesses by a small FSM. It adds parametrised data-memory depth and parametrised input/output peripheral port counts, and flags bad accesses with an error response instead of silently aliasing.

## Interface
- DMEM_AW, 10: data-memory byte-address width; DMEM occupies 0 .. 2**DMEM_AW-1 (DMEM_AW ≤ 10)
- NUM_IN, 2: input peripheral ports (1..16)
- NUM_OUT, 4: output peripheral ports (1..16)
- MISALIGN_EN, 1: 1 = split misaligned DMEM accesses, 0 = flag them as errors
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request may be accepted this cycle
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  zero-extend the load result (LBU/LHU)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, LSB-justified
- i_flush  in  1  squash the request presented this cycle, or an in-flight load
- o_rsp_valid  out  1  one-cycle response pulse; no backpressure
- o_rsp_data  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  access fault, qualified by o_rsp_valid
- i_in_port  in  32*NUM_IN  asynchronous input ports, port k at bits [32k+31:32k]
- o_out_port  out  32*NUM_OUT  output port registers

## Operation
- Address map (requires addr[31:11]==0):
  - DMEM: addr < 2**DMEM_AW.
  - Input port k: addr[10:8]==3'b100, k = addr[7:4] < NUM_IN.
  - Output port k: addr[10:8]==3'b101, k = addr[7:4] < NUM_OUT. Output ports are readable.
  - Any other address: error.
- Lanes: off = addr[1:0]. 8-bit mask = {byte 0001, half 0011, word 1111} << off. Write data = wdata << 8*off.
  - Mask bits [3:0] select bytes of word A = addr[DMEM_AW-1:2].
  - Mask bits [7:4] select bytes of word A+1.
- Misaligned means mask[7:4] != 0.
  - For peripherals, or when MISALIGN_EN=0, a misaligned access is an error.
  - For DMEM, a misaligned access whose last byte is ≥ 2**DMEM_AW is an error.
- An error has no side effect: no write, and the response carries o_rsp_err=1 with data 0. Size 11 is also an error.
- Input ports pass through a 2-flop synchroniser, so a load returns the pin value from ≥2 cycles earlier.
- Output ports are byte-enabled registers written with mask[3:0].
- FSM states: IDLE, SPLIT.
  - IDLE: o_req_ready=1. On accept (valid & ready & ~i_flush), word A is accessed that cycle.
  - A misaligned DMEM access moves to SPLIT. Everything else stays in IDLE and responds next cycle.
  - SPLIT: o_req_ready=0. Word A+1 is accessed, then the FSM returns to IDLE and responds next cycle.
- Load merge: word A is held in a register. Result = {wordA1, wordA} >> 8*off, then sign/zero-extended from bit 7 or bit 15 per size/unsigned.
- Flush:
  - i_flush with a request means no accept, no write, and no response.
  - i_flush during SPLIT of a load suppresses its response.
  - i_flush during SPLIT of a store is ignored; the store completes atomically.

## Timing
- Reset values: o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, all o_out_port=0, FSM=IDLE (so o_req_ready=1), synchronisers 0. DMEM contents are not reset.
- Aligned load/store: accepted at edge E0; response valid in the cycle after E0 (latency 1). Throughput is one access per cycle.
- Misaligned DMEM access: accepted at E0, second word at E1, response after E1 (latency 2). o_req_ready is low for the one cycle between.
- DMEM: synchronous read, data available 1 cycle after the address. A store and a load to the same word in consecutive cycles returns the new data, because the write completes at E0.
- Output port write is visible on o_out_port the cycle after acceptance.
- Reset asserted mid-SPLIT: the FSM returns to IDLE. The second half of a store is lost and no response is produced.

## Structure
- lsu_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - region constants (REG_IN=3'b100, REG_OUT=3'b101);
  - FSM state enum (ST_IDLE, ST_SPLIT);
  - the request struct.
- Sub-module dmem_be: single-port, byte-enable, synchronous-read RAM, parametrised by DMEM_AW, with a 4-bit write mask.
- Peripheral registers and synchronisers stay inline as generate loops.

## Test plan
- SW 0x11223344 to 0x10, then LW 0x10 → rsp one cycle later, data 0x11223344, err 0; next LB 0x13 → 0x00000011.
- SH 0xBEEF to 0x3 (misaligned) → o_req_ready low for 1 cycle; LW 0x0 → byte3=0xEF; LW 0x4 → byte0=0xBE; LH 0x3 → 0xFFFFBEEF; LHU 0x3 → 0x0000BEEF.
- SW 0xA5A5A5A5 to 0x510 → o_out_port[1] = 0xA5A5A5A5 the next cycle; SB 0xFF to 0x511 → port 1 = 0xA5A5FFA5.
- Drive i_in_port[0]=0xCAFEF00D, wait 2 cycles, LW 0x400 → 0xCAFEF00D; LW 0x600 → err=1, data 0; SW 0x3FE (DMEM_AW=10) → err=1, memory unchanged.
- Misaligned load with i_flush during SPLIT → no rsp. Misaligned store with i_flush during SPLIT → both words written. i_flush with SW to 0x500 → port 0 unchanged, no rsp.
- i_rst asserted mid-SPLIT of SW to 0x2 → outputs to reset values immediately; next request accepted the first cycle after deassertion.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane helpers for the lsu_v2 load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
  typedef enum logic {ST_IDLE, ST_SPLIT} state_e;
  localparam logic [2:0] REG_IN = 3'b100;
  localparam logic [2:0] REG_OUT = 3'b101;
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] b;
    b = size == SZ_BYTE ? 8'h01 : size == SZ_HALF ? 8'h03 : 8'h0f;
    return b << off;
  endfunction
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size, input logic uns);
    return size == SZ_BYTE ? {{24{~uns & w[7]}}, w[7:0]} :
           size == SZ_HALF ? {{16{~uns & w[15]}}, w[15:0]} : w;
  endfunction
endpackage

// File: rtl/dmem_be.sv
// dmem_be: single-port byte-enable RAM with synchronous read, contents not reset.
module dmem_be #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-3:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] mem_q [2**(AW-2)];
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we && i_be[b]) mem_q[i_addr][8*b+:8] <= i_wdata[8*b+:8];
    o_rdata <= mem_q[i_addr];
  end
endmodule

// File: rtl/lsu_v2.sv
// lsu_v2: RV32I load/store unit with DMEM, peripheral ports and misaligned-access splitting.
module lsu_v2
  import lsu_pkg::*;
#(
  parameter int DMEM_AW = 10,
  parameter int NUM_IN = 2,
  parameter int NUM_OUT = 4,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [31:0]          i_req_addr,
  input  logic [31:0]          i_req_wdata,
  input  logic                 i_flush,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_rsp_data,
  output logic                 o_rsp_err,
  input  logic [32*NUM_IN-1:0] i_in_port,
  output logic [32*NUM_OUT-1:0] o_out_port
);
  localparam int WW = DMEM_AW - 2;
  state_e state_q;
  req_t req;
  logic split, accept, hi_ok, is_dmem, is_in, is_out, mis, err, go_split, m_we;
  logic we_q, uns_q, dmem_q, mis_q, rsp_valid_q, rsp_err_q;
  logic [1:0] size_q, off_q;
  logic [3:0] port_k, m_be;
  logic [4:0] sh;
  logic [7:0] mk;
  logic [63:0] ws, w64;
  logic [31:0] in_w, out_w, m_rdata, m_wdata, pword_q, word_a_q, wd_q;
  logic [32*NUM_IN-1:0] sync_w;
  logic [WW-1:0] m_addr, a_q;
  assign req = '{we: i_req_we, size: i_req_size, uns: i_req_unsigned, addr: i_req_addr, wdata: i_req_wdata};
  assign split = state_q == ST_SPLIT;
  assign o_req_ready = !split;
  // Lane mask and shifted data serve the live request in IDLE and the held one in SPLIT.
  always_comb begin
    port_k = req.addr[7:4];
    hi_ok = req.addr[31:11] == '0;
    is_dmem = (req.addr >> DMEM_AW) == '0;
    is_in = hi_ok && req.addr[10:8] == REG_IN && int'(port_k) < NUM_IN;
    is_out = hi_ok && req.addr[10:8] == REG_OUT && int'(port_k) < NUM_OUT;
    sh = {split ? off_q : req.addr[1:0], 3'b000};
    mk = lane_mask(split ? size_q : req.size, split ? off_q : req.addr[1:0]);
    ws = {32'd0, split ? wd_q : req.wdata} << sh;
    mis = |mk[7:4];
    err = req.size == 2'b11 || !(is_dmem || is_in || is_out) ||
          (mis && (!is_dmem || !MISALIGN_EN || &req.addr[DMEM_AW-1:2]));
    accept = i_req_valid && !split && !i_flush;
    go_split = accept && mis && !err;
    m_we = split ? we_q : accept && req.we && is_dmem && !err;
    m_be = split ? mk[7:4] : mk[3:0];
    m_addr = split ? a_q + WW'(1) : req.addr[DMEM_AW-1:2];
    m_wdata = split ? ws[63:32] : ws[31:0];
    in_w = '0;
    for (int j = 0; j < NUM_IN; j++) if (port_k == 4'(j)) in_w = sync_w[32*j+:32];
    out_w = '0;
    for (int j = 0; j < NUM_OUT; j++) if (port_k == 4'(j)) out_w = o_out_port[32*j+:32];
    w64 = mis_q ? {m_rdata, word_a_q} : {32'd0, dmem_q ? m_rdata : pword_q};
  end
  dmem_be #(.AW(DMEM_AW)) u_dmem (
    .i_clk(i_clk), .i_we(m_we), .i_be(m_be), .i_addr(m_addr), .i_wdata(m_wdata), .o_rdata(m_rdata)
  );
  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    logic [31:0] s1_q, s2_q;
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        s1_q <= '0;
        s2_q <= '0;
      end else begin
        s1_q <= i_in_port[32*k+:32];
        s2_q <= s1_q;
      end
    assign sync_w[32*k+:32] = s2_q;
  end
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic [31:0] q;
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) q <= '0;
      else if (accept && req.we && is_out && !err && port_k == 4'(k))
        for (int b = 0; b < 4; b++) if (mk[b]) q[8*b+:8] <= ws[8*b+:8];
    assign o_out_port[32*k+:32] = q;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      we_q <= 1'b0;
      size_q <= '0;
      uns_q <= 1'b0;
      off_q <= '0;
      a_q <= '0;
      wd_q <= '0;
      dmem_q <= 1'b0;
      mis_q <= 1'b0;
      pword_q <= '0;
      word_a_q <= '0;
    end else begin
      if (accept) begin
        we_q <= req.we;
        size_q <= req.size;
        uns_q <= req.uns;
        off_q <= req.addr[1:0];
        a_q <= req.addr[DMEM_AW-1:2];
        wd_q <= req.wdata;
        dmem_q <= is_dmem;
        mis_q <= go_split;
        pword_q <= req.addr[8] ? out_w : in_w;
      end
      if (split) word_a_q <= m_rdata;
    end
  // A flush in SPLIT drops a load's response; a store always completes and responds.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else if (split) begin
      state_q <= ST_IDLE;
      rsp_valid_q <= we_q || !i_flush;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= go_split ? ST_SPLIT : ST_IDLE;
      rsp_valid_q <= accept && !go_split;
      rsp_err_q <= accept && err;
    end
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err = rsp_err_q;
  assign o_rsp_data = (rsp_valid_q && !rsp_err_q && !we_q) ?
                      extend(32'(w64 >> {off_q, 3'b000}), size_q, uns_q) : '0;
endmodule
